pdh_cmd_regfile: RTL and testbench

Parametrised PS-to-PL command decoder and register file for the PDH core. Replaces the fixed two-command LED decoder with:
- N-channel DAC setpoint registers and a per-channel enable mask;
- ADC snapshot readback;
- an acknowledge/error response word.

It sits between the AXI GPIO pair and the ADC/DAC AXI-Stream ports, and all PS software control of the loop goes through it.

---
 rtl/pdh_cmd_regfile.sv | 200 ++++++++++++++++++++
 tb/tb_pdh_cmd_regfile.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdh_cmd_regfile.sv
// PS-to-PL command decoder and register file for the PDH core: decodes strobed
// GPIO command words into LED, DAC setpoint/enable and ADC snapshot accesses.
module pdh_cmd_regfile #(
    parameter int NUM_DAC_CH         = 2,
    parameter int NUM_ADC_CH         = 2,
    parameter int LANE_WIDTH         = 16,
    parameter int DAC_DATA_WIDTH     = 14,
    parameter int AXI_GPIO_IN_WIDTH  = 32,
    parameter int AXI_GPIO_OUT_WIDTH = 32
) (
    input  logic                               clk,
    input  logic                               rst_ni,
    input  logic [NUM_ADC_CH*LANE_WIDTH-1:0]   adc_tdata_i,
    input  logic                               adc_tvalid_i,
    output logic [NUM_DAC_CH*LANE_WIDTH-1:0]   dac_tdata_o,
    output logic                               dac_tvalid_o,
    input  logic [AXI_GPIO_IN_WIDTH-1:0]       axi_from_ps_i,
    output logic [AXI_GPIO_OUT_WIDTH-1:0]      axi_to_ps_o,
    output logic [7:0]                         led_o
);

    localparam logic [3:0] CMD_IDLE       = 4'd0;
    localparam logic [3:0] CMD_SET_LED    = 4'd1;
    localparam logic [3:0] CMD_SET_DAC    = 4'd2;
    localparam logic [3:0] CMD_GET_DAC    = 4'd3;
    localparam logic [3:0] CMD_GET_ADC    = 4'd4;
    localparam logic [3:0] CMD_SET_DAC_EN = 4'd5;

    function automatic logic [15:0] sext16(input logic [DAC_DATA_WIDTH-1:0] v);
        return {{(16-DAC_DATA_WIDTH){v[DAC_DATA_WIDTH-1]}}, v};
    endfunction

    function automatic logic [LANE_WIDTH-1:0] sext_lane(input logic [DAC_DATA_WIDTH-1:0] v);
        return {{(LANE_WIDTH-DAC_DATA_WIDTH){v[DAC_DATA_WIDTH-1]}}, v};
    endfunction

    logic [AXI_GPIO_IN_WIDTH-1:0]      cmd_q;
    logic                              strb_prev_q;
    logic [7:0]                        led_q, led_d;
    logic [DAC_DATA_WIDTH-1:0]         dac_reg_q [NUM_DAC_CH];
    logic [DAC_DATA_WIDTH-1:0]         dac_reg_d [NUM_DAC_CH];
    logic [NUM_DAC_CH-1:0]             en_mask_q, en_mask_d;
    logic [NUM_ADC_CH*LANE_WIDTH-1:0]  adc_hold_q, adc_hold_d;
    logic [AXI_GPIO_OUT_WIDTH-1:0]     rsp_q, rsp_d;
    logic [NUM_DAC_CH*LANE_WIDTH-1:0]  dac_tdata_q, dac_tdata_d;
    logic                              dac_tvalid_q;

    logic                              exec_s;
    logic [3:0]                        op_s;
    logic [3:0]                        ch_s;
    logic [25:0]                       data_s;
    logic                              err_s;
    logic [25:0]                       pay_s;
    logic                              dac_hit_s;
    logic                              adc_hit_s;
    logic [DAC_DATA_WIDTH-1:0]         dac_sel_s;
    logic [LANE_WIDTH-1:0]             adc_sel_s;
    logic                              unused_s;

    assign unused_s = ^cmd_q;

    // Channel lookup: out-of-range channels report a miss instead of aliasing.
    always_comb begin
        exec_s    = cmd_q[30] & ~strb_prev_q;
        op_s      = cmd_q[29:26];
        data_s    = cmd_q[25:0];
        ch_s      = cmd_q[25:22];
        dac_hit_s = 1'b0;
        dac_sel_s = '0;
        adc_hit_s = 1'b0;
        adc_sel_s = '0;
        for (int k = 0; k < NUM_DAC_CH; k++) begin
            if (ch_s == 4'(k)) begin
                dac_hit_s = 1'b1;
                dac_sel_s = dac_reg_q[k];
            end else begin
                dac_hit_s = dac_hit_s;
            end
        end
        for (int k = 0; k < NUM_ADC_CH; k++) begin
            if (ch_s == 4'(k)) begin
                adc_hit_s = 1'b1;
                adc_sel_s = adc_hold_q[k*LANE_WIDTH +: LANE_WIDTH];
            end else begin
                adc_hit_s = adc_hit_s;
            end
        end
    end

    // Command execution; errors leave every register untouched but still answer.
    always_comb begin
        led_d     = led_q;
        dac_reg_d = dac_reg_q;
        en_mask_d = en_mask_q;
        rsp_d     = rsp_q;
        err_s     = 1'b0;
        pay_s     = 26'd0;
        if (exec_s) begin
            case (op_s)
                CMD_IDLE: begin
                    pay_s = 26'd0;
                end
                CMD_SET_LED: begin
                    led_d = data_s[7:0];
                    pay_s = {18'd0, data_s[7:0]};
                end
                CMD_SET_DAC: begin
                    if (dac_hit_s) begin
                        for (int k = 0; k < NUM_DAC_CH; k++) begin
                            if (ch_s == 4'(k)) begin
                                dac_reg_d[k] = data_s[DAC_DATA_WIDTH-1:0];
                            end else begin
                                dac_reg_d[k] = dac_reg_q[k];
                            end
                        end
                        pay_s = {ch_s, 6'd0, sext16(data_s[DAC_DATA_WIDTH-1:0])};
                    end else begin
                        err_s = 1'b1;
                    end
                end
                CMD_GET_DAC: begin
                    if (dac_hit_s) begin
                        pay_s = {ch_s, 6'd0, sext16(dac_sel_s)};
                    end else begin
                        err_s = 1'b1;
                    end
                end
                CMD_GET_ADC: begin
                    if (adc_hit_s) begin
                        pay_s = {ch_s, 6'd0, 16'(adc_sel_s)};
                    end else begin
                        err_s = 1'b1;
                    end
                end
                CMD_SET_DAC_EN: begin
                    en_mask_d = data_s[NUM_DAC_CH-1:0];
                    pay_s     = 26'(data_s[NUM_DAC_CH-1:0]);
                end
                default: begin
                    err_s = 1'b1;
                end
            endcase
            rsp_d = AXI_GPIO_OUT_WIDTH'({op_s, ~rsp_q[27], err_s, pay_s});
        end else begin
            rsp_d = rsp_q;
        end
    end

    // DAC lane image and ADC snapshot next state.
    always_comb begin
        dac_tdata_d = '0;
        for (int k = 0; k < NUM_DAC_CH; k++) begin
            if (en_mask_q[k]) begin
                dac_tdata_d[k*LANE_WIDTH +: LANE_WIDTH] = sext_lane(dac_reg_q[k]);
            end else begin
                dac_tdata_d[k*LANE_WIDTH +: LANE_WIDTH] = '0;
            end
        end
        if (adc_tvalid_i) begin
            adc_hold_d = adc_tdata_i;
        end else begin
            adc_hold_d = adc_hold_q;
        end
    end

    // State registers; reset discards any pending strobe edge.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q        <= '0;
            strb_prev_q  <= 1'b0;
            led_q        <= 8'd0;
            en_mask_q    <= '0;
            adc_hold_q   <= '0;
            rsp_q        <= '0;
            dac_tdata_q  <= '0;
            dac_tvalid_q <= 1'b0;
            for (int k = 0; k < NUM_DAC_CH; k++) begin
                dac_reg_q[k] <= '0;
            end
        end else begin
            cmd_q        <= axi_from_ps_i;
            strb_prev_q  <= cmd_q[30];
            led_q        <= led_d;
            en_mask_q    <= en_mask_d;
            adc_hold_q   <= adc_hold_d;
            rsp_q        <= rsp_d;
            dac_tdata_q  <= dac_tdata_d;
            dac_tvalid_q <= 1'b1;
            for (int k = 0; k < NUM_DAC_CH; k++) begin
                dac_reg_q[k] <= dac_reg_d[k];
            end
        end
    end

    assign dac_tdata_o  = dac_tdata_q;
    assign dac_tvalid_o = dac_tvalid_q;
    assign axi_to_ps_o  = rsp_q;
    assign led_o        = led_q;

endmodule

// File: tb/tb_pdh_cmd_regfile.sv
// Directed bench for pdh_cmd_regfile: a cycle model built from the command
// rules is compared every cycle, plus hand-computed literal checkpoints.
module tb_pdh_cmd_regfile;

    logic        clk;
    logic        rst_n;
    logic [31:0] adc_tdata;
    logic        adc_tvalid;
    logic [31:0] dac_tdata;
    logic        dac_tvalid;
    logic [31:0] axi_from_ps;
    logic [31:0] axi_to_ps;
    logic [7:0]  led;

    int tests = 0;
    int fails = 0;

    pdh_cmd_regfile dut (
        .clk          (clk),
        .rst_ni       (rst_n),
        .adc_tdata_i  (adc_tdata),
        .adc_tvalid_i (adc_tvalid),
        .dac_tdata_o  (dac_tdata),
        .dac_tvalid_o (dac_tvalid),
        .axi_from_ps_i(axi_from_ps),
        .axi_to_ps_o  (axi_to_ps),
        .led_o        (led)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_cmd, m_rsp, m_lanes, m_adc;
    logic        m_prev, m_ack, m_valid;
    logic [7:0]  m_led;
    logic [13:0] m_dac [2];
    logic [1:0]  m_en;

    function automatic logic [15:0] sx16(input logic [13:0] v);
        int s;
        s = int'(v);
        if (s >= 8192) s = s - 16384;
        return 16'(s);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cmd = 0; m_rsp = 0; m_lanes = 0; m_adc = 0;
                m_prev = 0; m_ack = 0; m_valid = 0; m_led = 0;
                m_dac[0] = 0; m_dac[1] = 0; m_en = 0;
            end else begin
                logic [31:0] nl;
                nl = 0;
                for (int k = 0; k < 2; k++)
                    if (m_en[k]) nl = nl | (32'(sx16(m_dac[k])) << (16 * k));
                m_lanes = nl;
                m_valid = 1;
                if (m_cmd[30] && !m_prev) begin
                    int op, ch;
                    logic [25:0] d;
                    logic [31:0] pay;
                    logic err;
                    op = int'(m_cmd[29:26]);
                    d = m_cmd[25:0];
                    ch = int'(d[25:22]);
                    err = 0;
                    pay = 0;
                    case (op)
                        0: pay = 0;
                        1: begin m_led = d[7:0]; pay = 32'(m_led); end
                        2: if (ch < 2) begin
                               m_dac[ch] = d[13:0];
                               pay = (32'(ch) << 22) | 32'(sx16(d[13:0]));
                           end else err = 1;
                        3: if (ch < 2) pay = (32'(ch) << 22) | 32'(sx16(m_dac[ch]));
                           else err = 1;
                        4: if (ch < 2) pay = (32'(ch) << 22) | ((m_adc >> (16 * ch)) & 32'hFFFF);
                           else err = 1;
                        5: begin m_en = d[1:0]; pay = 32'(m_en); end
                        default: err = 1;
                    endcase
                    m_ack = !m_ack;
                    m_rsp = (32'(op) << 28) | (32'(m_ack) << 27) | (32'(err) << 26) | pay;
                end
                m_prev = m_cmd[30];
                m_cmd = axi_from_ps;
                if (adc_tvalid) m_adc = adc_tdata;
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("led", 64'(led), 64'(m_led));
            chk("rsp", 64'(axi_to_ps), 64'(m_rsp));
            chk("dac_tdata", 64'(dac_tdata), 64'(m_lanes));
            chk("dac_tvalid", 64'(dac_tvalid), 64'(m_valid));
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] op, input logic [25:0] d);
        @(negedge clk);
        axi_from_ps = {1'b0, 1'b1, op, d};
        wait_edges(1);
        @(negedge clk);
        axi_from_ps = 32'd0;
        wait_edges(2);
    endtask

    initial begin
        rst_n = 1'b0;
        adc_tdata = 32'd0;
        adc_tvalid = 1'b0;
        axi_from_ps = 32'd0;
        wait_edges(3);
        chk("reset_rsp", 64'(axi_to_ps), 64'd0);
        chk("reset_dac", 64'(dac_tdata), 64'd0);
        chk("reset_led", 64'(led), 64'd0);
        chk("reset_tvalid", 64'(dac_tvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(1);
        chk("tvalid_after_release", 64'(dac_tvalid), 64'd1);
        wait_edges(100);
        chk("idle_no_ack", 64'(axi_to_ps), 64'd0);

        // SET_LED with strobe held high for 10 cycles
        @(negedge clk);
        axi_from_ps = {1'b0, 1'b1, 4'd1, 26'h0A5};
        wait_edges(1);
        chk("led_edge_k", 64'(led), 64'd0);
        wait_edges(1);
        chk("led_edge_k1", 64'(led), 64'hA5);
        chk("rsp_set_led", 64'(axi_to_ps), 64'h180000A5);
        wait_edges(8);
        chk("rsp_held_once", 64'(axi_to_ps), 64'h180000A5);
        @(negedge clk);
        axi_from_ps = 32'd0;
        wait_edges(2);

        cmd(4'd2, {4'd1, 8'd0, 14'h3FFF});
        cmd(4'd5, 26'd2);
        chk("lanes_en1", 64'(dac_tdata), 64'hFFFF0000);
        cmd(4'd3, {4'd1, 22'd0});
        chk("rsp_get_dac", 64'(axi_to_ps), 64'h3040FFFF);

        @(negedge clk);
        adc_tdata = 32'h0000_1234;
        adc_tvalid = 1'b1;
        @(negedge clk);
        adc_tvalid = 1'b0;
        adc_tdata = 32'h0000_5678;
        cmd(4'd4, 26'd0);
        chk("get_adc_low", 64'(axi_to_ps[15:0]), 64'h1234);
        chk("get_adc_err", 64'(axi_to_ps[26]), 64'd0);

        cmd(4'd2, {4'd5, 8'd0, 14'h0123});
        chk("rsp_bad_ch", 64'(axi_to_ps), 64'h24000000);
        cmd(4'd9, 26'h3FFFFFF);
        chk("rsp_bad_cmd", 64'(axi_to_ps), 64'h9C000000);
        chk("led_kept", 64'(led), 64'hA5);
        chk("lanes_kept", 64'(dac_tdata), 64'hFFFF0000);

        // Extra patterns covered by the model
        cmd(4'd2, {4'd0, 8'd0, 14'h2000});
        cmd(4'd5, 26'd3);
        chk("lanes_neg", 64'(dac_tdata), 64'hFFFFE000);
        cmd(4'd4, {4'd3, 22'd0});
        cmd(4'd3, {4'd2, 22'd0});
        cmd(4'd3, 26'd0);
        cmd(4'd0, 26'd0);
        @(negedge clk);
        adc_tdata = 32'hBEEF_4321;
        adc_tvalid = 1'b1;
        cmd(4'd4, {4'd1, 22'd0});
        adc_tvalid = 1'b0;
        cmd(4'd1, 26'h3FFFF5A);

        // Reset pulse between sample and commit of a SET_LED
        @(negedge clk);
        axi_from_ps = {1'b0, 1'b1, 4'd1, 26'h03C};
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        wait_edges(2);
        chk("led_in_reset", 64'(led), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(1);
        chk("led_after_release", 64'(led), 64'd0);
        wait_edges(1);
        chk("led_replayed", 64'(led), 64'h3C);
        chk("rsp_replayed", 64'(axi_to_ps), 64'h1800003C);
        wait_edges(5);
        chk("rsp_replay_once", 64'(axi_to_ps), 64'h1800003C);
        @(negedge clk);
        axi_from_ps = 32'd0;
        wait_edges(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
